// File: rtl/wb_slave_to_avalon_master_pkg.sv
// wb_slave_to_avalon_master_pkg: bridge state encoding and counter sizing helper
package wb_slave_to_avalon_master_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_CMD  = 3'd1,
    ST_RD_CMD  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_ACK     = 3'd4,
    ST_ERR     = 3'd5
  } state_e;
  function automatic int cnt_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction
endpackage

// File: rtl/wb_slave_to_avalon_master_if.sv
// wb_slave_to_avalon_master_if: Wishbone classic and Avalon-MM bus bundles
interface wb_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic                    wb_we_i;
  logic [ADDR_WIDTH-1:0]   wb_adr_i;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic [DATA_WIDTH/8-1:0] wb_sel_i;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic                    wb_ack_o;
  logic                    wb_err_o;
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

interface av_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   av_address;
  logic                    av_chipselect;
  logic [DATA_WIDTH/8-1:0] av_byteenable;
  logic                    av_read;
  logic                    av_write;
  logic [DATA_WIDTH-1:0]   av_writedata;
  logic [DATA_WIDTH-1:0]   av_readdata;
  logic                    av_readdatavalid;
  logic                    av_waitrequest;
  modport master (
    output av_address, av_chipselect, av_byteenable, av_read, av_write, av_writedata,
    input  av_readdata, av_readdatavalid, av_waitrequest
  );
  modport slave (
    input  av_address, av_chipselect, av_byteenable, av_read, av_write, av_writedata,
    output av_readdata, av_readdatavalid, av_waitrequest
  );
endinterface

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter: saturating cycle counter flagging LIMIT cycles of activity; LIMIT=0 never expires
module bus_timeout_counter #(
  parameter int WIDTH = 10,
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int LAST = (LIMIT > 0) ? LIMIT - 1 : 0;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             at_last;
  always_comb begin
    at_last = cnt_q == WIDTH'(LAST);
    cnt_d   = clr ? '0 : (en && !at_last) ? cnt_q + 1'b1 : cnt_q;
  end
  assign expired = (LIMIT > 0) && at_last;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wb_slave_to_avalon_master.sv
// wb_slave_to_avalon_master: Wishbone classic slave to Avalon-MM master, one transfer outstanding
// Outputs are registered from the next state, so each pulse lines up with its state.
module wb_slave_to_avalon_master
  import wb_slave_to_avalon_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_BYTES = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 1024
) (
  input logic      clk,
  input logic      rst_n,
  wb_bus_if.slave  wb,
  av_bus_if.master av
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [DATA_BYTES-1:0] sel_q, sel_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  wr_q, wr_d, rd_q, rd_d, ack_q, ack_d, err_q, err_d, abort_q, abort_d;
  logic                  busy, expired, req, fin, cap, abort;

  assign busy = state_q inside {ST_WR_CMD, ST_RD_CMD, ST_RD_WAIT};

  bus_timeout_counter #(
    .WIDTH(cnt_width(TIMEOUT)),
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!busy),
    .en     (busy),
    .expired(expired)
  );

  always_comb begin
    req   = state_q == ST_IDLE && wb.wb_cyc_i && wb.wb_stb_i;
    abort = abort_q || !wb.wb_cyc_i;
    cap   = (state_q == ST_RD_CMD && !av.av_waitrequest && av.av_readdatavalid) ||
            (state_q == ST_RD_WAIT && av.av_readdatavalid);
    fin   = cap || (state_q == ST_WR_CMD && !av.av_waitrequest);
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (req) state_d = wb.wb_we_i ? ST_WR_CMD : ST_RD_CMD;
      ST_RD_CMD:      if (!av.av_waitrequest) state_d = ST_RD_WAIT;
      ST_ACK, ST_ERR: state_d = ST_IDLE;
      default:        state_d = state_q;
    endcase
    // Completion beats timeout; an abandoned WB cycle finishes silently.
    if (fin) state_d = abort ? ST_IDLE : ST_ACK;
    else if (busy && expired && state_d == state_q) state_d = abort ? ST_IDLE : ST_ERR;
    adr_d   = req ? wb.wb_adr_i : adr_q;
    dat_d   = req ? wb.wb_dat_i : dat_q;
    sel_d   = req ? wb.wb_sel_i : sel_q;
    rdata_d = cap ? av.av_readdata : rdata_q;
    abort_d = busy && abort;
    wr_d    = state_d == ST_WR_CMD;
    rd_d    = state_d == ST_RD_CMD;
    ack_d   = state_d == ST_ACK;
    err_d   = state_d == ST_ERR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign wb.wb_dat_o      = rdata_q;
  assign wb.wb_ack_o      = ack_q;
  assign wb.wb_err_o      = err_q;
  assign av.av_address    = adr_q;
  assign av.av_writedata  = dat_q;
  assign av.av_byteenable = sel_q;
  assign av.av_read       = rd_q;
  assign av.av_write      = wr_q;
  assign av.av_chipselect = rd_q || wr_q;
endmodule

// File: tb/tb_wb_slave_to_avalon_master.sv
// tb_wb_slave_to_avalon_master: directed checks of the WB-to-Avalon bridge with TIMEOUT=8
module tb_wb_slave_to_avalon_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rd_n, err_n, ack_n;

  always #5 clk = ~clk;

  wb_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();
  av_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) av ();

  wb_slave_to_avalon_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DATA_BYTES(4),
    .TIMEOUT   (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wb   (wb),
    .av   (av)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_adr_i = a;
    wb.wb_dat_i = d;
    wb.wb_sel_i = s;
  endtask

  task automatic drop;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
  endtask

  initial begin
    drop();
    wb.wb_we_i = 1'b0;
    wb.wb_adr_i = '0;
    wb.wb_dat_i = '0;
    wb.wb_sel_i = '0;
    av.av_readdata = '0;
    av.av_readdatavalid = 1'b0;
    av.av_waitrequest = 1'b0;
    tick();
    tick();
    check("rst_ack", wb.wb_ack_o, 0);
    check("rst_err", wb.wb_err_o, 0);
    check("rst_dat", wb.wb_dat_o, 0);
    check("rst_cs", av.av_chipselect, 0);
    check("rst_rdwr", {av.av_read, av.av_write}, 0);
    rst_n = 1'b1;
    tick();

    // zero-wait write
    req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    tick();
    check("wr_write", av.av_write, 1);
    check("wr_cs", av.av_chipselect, 1);
    check("wr_addr", av.av_address, 32'h10);
    check("wr_data", av.av_writedata, 32'hDEADBEEF);
    check("wr_be", av.av_byteenable, 4'hF);
    check("wr_ack_early", wb.wb_ack_o, 0);
    tick();
    check("wr_ack", wb.wb_ack_o, 1);
    check("wr_write_off", av.av_write, 0);
    drop();
    tick();
    check("wr_ack_once", wb.wb_ack_o, 0);
    check("wr_dat_keep", wb.wb_dat_o, 0);

    // read: 3 waitrequest cycles, accept, data 2 cycles later
    req(1'b0, 32'h20, 32'h0, 4'hF);
    av.av_waitrequest = 1'b1;
    tick();
    check("rd_read1", av.av_read, 1);
    tick();
    tick();
    check("rd_read3", av.av_read, 1);
    tick();
    av.av_waitrequest = 1'b0;
    tick();
    check("rd_wait_read_off", av.av_read, 0);
    tick();
    check("rd_no_ack_yet", wb.wb_ack_o, 0);
    av.av_readdatavalid = 1'b1;
    av.av_readdata = 32'h12345678;
    tick();
    av.av_readdatavalid = 1'b0;
    check("rd_ack", wb.wb_ack_o, 1);
    check("rd_dat", wb.wb_dat_o, 32'h12345678);
    drop();
    tick();
    check("rd_ack_once", wb.wb_ack_o, 0);

    // read with data in the accept cycle; stray valid in IDLE is ignored
    av.av_readdatavalid = 1'b1;
    av.av_readdata = 32'hFFFF0000;
    req(1'b0, 32'h30, 32'h0, 4'hF);
    tick();
    check("rd0_ignore", wb.wb_dat_o, 32'h12345678);
    av.av_readdata = 32'hA5A5A5A5;
    tick();
    av.av_readdatavalid = 1'b0;
    check("rd0_ack", wb.wb_ack_o, 1);
    check("rd0_dat", wb.wb_dat_o, 32'hA5A5A5A5);
    drop();
    tick();
    check("rd0_ack_once", wb.wb_ack_o, 0);

    // hung slave: timeout after 8 cycles
    req(1'b0, 32'h40, 32'h0, 4'hF);
    av.av_waitrequest = 1'b1;
    rd_n = 0;
    err_n = 0;
    ack_n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      rd_n += int'(av.av_read);
      err_n += int'(wb.wb_err_o);
      ack_n += int'(wb.wb_ack_o);
      if (wb.wb_err_o) drop();
    end
    check("to_read_cycles", rd_n, 8);
    check("to_err_pulses", err_n, 1);
    check("to_no_ack", ack_n, 0);
    av.av_waitrequest = 1'b0;
    req(1'b1, 32'h44, 32'h0BADF00D, 4'h3);
    tick();
    check("to_wr_be", av.av_byteenable, 4'h3);
    tick();
    check("to_wr_ack", wb.wb_ack_o, 1);
    check("to_wr_err", wb.wb_err_o, 0);
    drop();
    tick();

    // abort during RD_WAIT: transfer finishes silently, data still captured
    req(1'b0, 32'h50, 32'h0, 4'hF);
    tick();
    tick();
    drop();
    check("ab_read_off", av.av_read, 0);
    tick();
    av.av_readdatavalid = 1'b1;
    av.av_readdata = 32'hCAFEF00D;
    tick();
    av.av_readdatavalid = 1'b0;
    check("ab_no_ack", wb.wb_ack_o, 0);
    check("ab_no_err", wb.wb_err_o, 0);
    check("ab_dat", wb.wb_dat_o, 32'hCAFEF00D);
    tick();
    check("ab_quiet", {wb.wb_ack_o, wb.wb_err_o}, 0);

    // reset while stalled in WR_CMD, stb held through reset
    req(1'b1, 32'h60, 32'h11223344, 4'hF);
    av.av_waitrequest = 1'b1;
    tick();
    check("rs_write_pre", av.av_write, 1);
    rst_n = 1'b0;
    tick();
    check("rs_write", av.av_write, 0);
    check("rs_cs", av.av_chipselect, 0);
    check("rs_addr", av.av_address, 0);
    check("rs_dat", wb.wb_dat_o, 0);
    check("rs_state", 64'(dut.state_q), 0);
    rst_n = 1'b1;
    av.av_waitrequest = 1'b0;
    tick();
    check("rs_restart", av.av_write, 1);
    check("rs_restart_addr", av.av_address, 32'h60);
    tick();
    check("rs_ack", wb.wb_ack_o, 1);
    drop();
    tick();
    check("rs_ack_once", wb.wb_ack_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
